// File: rtl/spy_fifo_wr_arb.sv
// spy_fifo_wr_arb: packet-locked round-robin arbiter sharing one SpyBuffer FIFO write port.
// The grant is held until the owner's last beat, or until the idle watchdog releases a stalled owner.
module spy_fifo_wr_arb #(
  parameter  int NREQ    = 4,
  parameter  int DWIDTH  = 32,
  parameter  int MAXIDLE = 64,
  localparam int GW      = $clog2(NREQ)
) (
  input  logic                   wclk,
  input  logic                   wrst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_last,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   wfull,
  output logic                   winc,
  output logic [DWIDTH-1:0]      wdata,
  output logic [GW-1:0]          grant_id,
  output logic                   busy,
  output logic                   pkt_timeout,
  output logic [15:0]            timeout_cnt
);

  // state  | meaning
  // S_IDLE | no owner; round-robin pick among valid requesters, no beats move
  // S_LOCK | r_owner holds the write port until its last beat or a watchdog release
  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOCK = 1'b1
  } state_t;

  localparam int IW = $clog2(MAXIDLE + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [GW-1:0]     r_owner;
  logic [GW-1:0]     r_last_owner;
  logic [IW-1:0]     r_idle_cnt;
  logic              r_pkt_timeout;
  logic [15:0]       r_timeout_cnt;

  logic [DWIDTH-1:0] w_data_arr [NREQ];
  logic [GW-1:0]     w_pick;
  logic              w_pick_vld;
  logic              w_lock;
  logic              w_beat;
  logic              w_last_beat;
  logic              w_idle_tick;
  logic              w_timeout;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_data_arr[gi] = req_data[gi*DWIDTH +: DWIDTH];
  end

  // Search starts just above the previous owner so every requester gets a turn.
  always_comb begin
    w_pick     = '0;
    w_pick_vld = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_pick_vld && req_valid[(int'(r_last_owner) + k) % NREQ]) begin
        w_pick     = GW'((int'(r_last_owner) + k) % NREQ);
        w_pick_vld = 1'b1;
      end
    end
  end

  assign w_lock      = (r_state == S_LOCK);
  assign w_beat      = w_lock & req_valid[r_owner] & ~wfull;
  assign w_last_beat = w_beat & req_last[r_owner];
  // Only an absent owner counts as idle; a full FIFO stalls without charging the owner.
  assign w_idle_tick = w_lock & ~req_valid[r_owner];
  assign w_timeout   = w_idle_tick & (r_idle_cnt == IW'(MAXIDLE - 1));

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_pick_vld) w_state_nxt = S_LOCK;
      S_LOCK:  if (w_last_beat || w_timeout) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    winc      = 1'b0;
    wdata     = '0;
    if (w_lock) begin
      req_ready[r_owner] = ~wfull;
      winc               = req_valid[r_owner] & ~wfull;
      wdata              = w_data_arr[r_owner];
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_owner       <= '0;
      r_last_owner  <= GW'(NREQ - 1);
      r_idle_cnt    <= '0;
      r_pkt_timeout <= 1'b0;
      r_timeout_cnt <= '0;
    end else begin
      r_pkt_timeout <= w_timeout;
      if ((r_state == S_IDLE) && w_pick_vld) begin
        r_owner    <= w_pick;
        r_idle_cnt <= '0;
      end else if (w_last_beat || w_timeout) begin
        r_last_owner <= r_owner;
        r_idle_cnt   <= '0;
      end else if (w_beat) begin
        r_idle_cnt <= '0;
      end else if (w_idle_tick) begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end
      if (w_timeout && (r_timeout_cnt != 16'hFFFF)) begin
        r_timeout_cnt <= r_timeout_cnt + 1'b1;
      end
    end
  end

  assign busy        = w_lock;
  assign grant_id    = r_owner;
  assign pkt_timeout = r_pkt_timeout;
  assign timeout_cnt = r_timeout_cnt;

endmodule

// File: tb/tb_spy_fifo_wr_arb.sv
// Directed self-checking bench for spy_fifo_wr_arb (4 requesters, 32-bit data, 8-cycle watchdog).
module tb_spy_fifo_wr_arb;

  logic         wclk;
  logic         wrst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_last;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         wfull;
  logic         winc;
  logic [31:0]  wdata;
  logic [1:0]   grant_id;
  logic         busy;
  logic         pkt_timeout;
  logic [15:0]  timeout_cnt;

  logic [31:0]  d [4];
  int           rr_b [4];
  int           n_vec;
  int           n_err;

  assign req_data = {d[3], d[2], d[1], d[0]};

  spy_fifo_wr_arb #(.NREQ(4), .DWIDTH(32), .MAXIDLE(8)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .wfull(wfull), .winc(winc),
    .wdata(wdata), .grant_id(grant_id), .busy(busy), .pkt_timeout(pkt_timeout),
    .timeout_cnt(timeout_cnt)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic cyc();
    @(posedge wclk);
    #1;
  endtask

  task automatic clr();
    req_valid = '0;
    req_last  = '0;
    wfull     = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = '0;
  endtask

  task automatic test_reset();
    clr();
    wrst_n = 1'b1;
    #1 wrst_n = 1'b0;
    #1;
    n_vec++; if (winc !== 1'b0) begin n_err++; $display("FAIL reset_winc: got %0b want 0", winc); end
    n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_vec++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
    n_vec++; if (pkt_timeout !== 1'b0) begin n_err++; $display("FAIL reset_pto: got %0b want 0", pkt_timeout); end
    n_vec++; if (timeout_cnt !== 16'd0) begin n_err++; $display("FAIL reset_tocnt: got %0h want 0", timeout_cnt); end
    n_vec++; if (wdata !== 32'd0) begin n_err++; $display("FAIL reset_wdata: got %0h want 0", wdata); end
    #2 wrst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    clr();
    req_valid[2] = 1'b1;
    d[2] = 32'hA0;
    @(negedge wclk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle_busy: got %0b want 0", busy); end
    for (int w = 0; w < 4; w++) begin
      cyc();
      d[2] = 32'hA0 + 32'(w);
      req_last[2] = (w == 3);
      @(negedge wclk);
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy w%0d: got %0b want 1", w, busy); end
      n_vec++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL single_grant w%0d: got %0d want 2", w, grant_id); end
      n_vec++; if (winc !== 1'b1) begin n_err++; $display("FAIL single_winc w%0d: got %0b want 1", w, winc); end
      n_vec++; if (wdata !== 32'hA0 + 32'(w)) begin n_err++; $display("FAIL single_wdata w%0d: got %0h want %0h", w, wdata, 32'hA0 + 32'(w)); end
      n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready w%0d: got %b want 0100", w, req_ready); end
    end
    cyc();
    clr();
    @(negedge wclk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_end_busy: got %0b want 0", busy); end
    n_vec++; if (winc !== 1'b0) begin n_err++; $display("FAIL single_end_winc: got %0b want 0", winc); end
    n_vec++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL single_end_grant: got %0d want 2", grant_id); end
    cyc();
  endtask

  task automatic rr_drive();
    req_valid = 4'hF;
    wfull = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_last[i] = (rr_b[i] == 1);
      d[i] = 32'(32'h100 * i + rr_b[i]);
    end
  endtask

  task automatic test_round_robin();
    clr();
    wrst_n = 1'b0;
    #1 wrst_n = 1'b1;
    for (int i = 0; i < 4; i++) rr_b[i] = 0;
    for (int p = 0; p < 8; p++) begin
      int k;
      k = p % 4;
      rr_drive();
      @(negedge wclk);
      n_vec++; if (busy !== 1'b0 || winc !== 1'b0) begin n_err++; $display("FAIL rr_bubble p%0d: busy %0b winc %0b want 0 0", p, busy, winc); end
      for (int w = 0; w < 2; w++) begin
        cyc();
        rr_drive();
        @(negedge wclk);
        n_vec++; if (grant_id !== 2'(k)) begin n_err++; $display("FAIL rr_grant p%0d w%0d: got %0d want %0d", p, w, grant_id, k); end
        n_vec++; if (winc !== 1'b1) begin n_err++; $display("FAIL rr_winc p%0d w%0d: got %0b want 1", p, w, winc); end
        n_vec++; if (wdata !== 32'(32'h100 * k + w)) begin n_err++; $display("FAIL rr_wdata p%0d w%0d: got %0h want %0h", p, w, wdata, 32'h100 * k + w); end
        n_vec++; if (req_ready !== (4'b0001 << k)) begin n_err++; $display("FAIL rr_ready p%0d w%0d: got %b want %b", p, w, req_ready, 4'b0001 << k); end
        rr_b[k] = 1 - rr_b[k];
      end
      cyc();
    end
  endtask

  task automatic test_backpressure();
    clr();
    req_valid[1] = 1'b1;
    d[1] = 32'hB0;
    @(negedge wclk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_idle_busy: got %0b want 0", busy); end
    cyc();
    @(negedge wclk);
    n_vec++; if (winc !== 1'b1 || wdata !== 32'hB0 || grant_id !== 2'd1) begin
      n_err++; $display("FAIL bp_first: winc %0b wdata %0h grant %0d want 1 b0 1", winc, wdata, grant_id);
    end
    cyc();
    d[1] = 32'hB1;
    wfull = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge wclk);
      n_vec++; if (winc !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b1) begin
        n_err++; $display("FAIL bp_stall c%0d: winc %0b ready %b busy %0b want 0 0000 1", c, winc, req_ready, busy);
      end
      cyc();
    end
    // Seven idle cycles after the stall: a watchdog that advanced during wfull would fire here.
    wfull = 1'b0;
    req_valid[1] = 1'b0;
    req_last[1] = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge wclk);
      n_vec++; if (busy !== 1'b1 || pkt_timeout !== 1'b0 || winc !== 1'b0) begin
        n_err++; $display("FAIL bp_idle c%0d: busy %0b pto %0b winc %0b want 1 0 0", c, busy, pkt_timeout, winc);
      end
      cyc();
    end
    req_valid[1] = 1'b1;
    for (int w = 1; w < 4; w++) begin
      d[1] = 32'hB0 + 32'(w);
      req_last[1] = (w == 3);
      @(negedge wclk);
      n_vec++; if (winc !== 1'b1 || wdata !== 32'hB0 + 32'(w)) begin
        n_err++; $display("FAIL bp_resume w%0d: winc %0b wdata %0h want 1 %0h", w, winc, wdata, 32'hB0 + 32'(w));
      end
      cyc();
    end
    clr();
    @(negedge wclk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_end_busy: got %0b want 0", busy); end
    cyc();
  endtask

  task automatic test_watchdog();
    clr();
    req_valid[0] = 1'b1;
    d[0] = 32'hC0;
    @(negedge wclk);
    n_vec++; if (busy !== 1'b0 || timeout_cnt !== 16'd0) begin
      n_err++; $display("FAIL wd_start: busy %0b tocnt %0h want 0 0", busy, timeout_cnt);
    end
    cyc();
    @(negedge wclk);
    n_vec++; if (winc !== 1'b1 || grant_id !== 2'd0) begin
      n_err++; $display("FAIL wd_first: winc %0b grant %0d want 1 0", winc, grant_id);
    end
    cyc();
    req_valid = 4'b1000;
    req_last  = 4'b1000;
    d[0] = 32'hC1;
    d[3] = 32'hD0;
    for (int c = 0; c < 8; c++) begin
      @(negedge wclk);
      n_vec++; if (busy !== 1'b1 || pkt_timeout !== 1'b0 || winc !== 1'b0) begin
        n_err++; $display("FAIL wd_wait c%0d: busy %0b pto %0b winc %0b want 1 0 0", c, busy, pkt_timeout, winc);
      end
      cyc();
    end
    @(negedge wclk);
    n_vec++; if (busy !== 1'b0 || pkt_timeout !== 1'b1) begin
      n_err++; $display("FAIL wd_fire: busy %0b pto %0b want 0 1", busy, pkt_timeout);
    end
    n_vec++; if (timeout_cnt !== 16'd1) begin n_err++; $display("FAIL wd_cnt: got %0h want 1", timeout_cnt); end
    cyc();
    @(negedge wclk);
    n_vec++; if (pkt_timeout !== 1'b0 || grant_id !== 2'd3 || winc !== 1'b1 || wdata !== 32'hD0) begin
      n_err++; $display("FAIL wd_next: pto %0b grant %0d winc %0b wdata %0h want 0 3 1 d0", pkt_timeout, grant_id, winc, wdata);
    end
    cyc();
    clr();
    @(negedge wclk);
    n_vec++; if (busy !== 1'b0 || timeout_cnt !== 16'd1) begin
      n_err++; $display("FAIL wd_end: busy %0b tocnt %0h want 0 1", busy, timeout_cnt);
    end
    cyc();
  endtask

  task automatic test_saturation();
    clr();
    force dut.r_timeout_cnt = 16'hFFFE;
    #1 release dut.r_timeout_cnt;
    for (int r = 1; r < 3; r++) begin
      req_valid[r] = 1'b1;
      cyc();
      req_valid[r] = 1'b0;
      repeat (8) cyc();
      @(negedge wclk);
      n_vec++; if (pkt_timeout !== 1'b1) begin n_err++; $display("FAIL sat_pto r%0d: got %0b want 1", r, pkt_timeout); end
      n_vec++; if (timeout_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_cnt r%0d: got %0h want ffff", r, timeout_cnt); end
      cyc();
    end
  endtask

  task automatic test_async_reset();
    clr();
    req_valid[2] = 1'b1;
    d[2] = 32'hE0;
    cyc();
    @(negedge wclk);
    n_vec++; if (winc !== 1'b1 || wdata !== 32'hE0) begin
      n_err++; $display("FAIL ar_first: winc %0b wdata %0h want 1 e0", winc, wdata);
    end
    cyc();
    d[2] = 32'hE1;
    #1 wrst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0 || winc !== 1'b0 || req_ready !== 4'b0) begin
      n_err++; $display("FAIL ar_ctrl: busy %0b winc %0b ready %b want 0 0 0000", busy, winc, req_ready);
    end
    n_vec++; if (grant_id !== 2'd0 || wdata !== 32'd0) begin
      n_err++; $display("FAIL ar_data: grant %0d wdata %0h want 0 0", grant_id, wdata);
    end
    n_vec++; if (timeout_cnt !== 16'd0 || pkt_timeout !== 1'b0) begin
      n_err++; $display("FAIL ar_to: tocnt %0h pto %0b want 0 0", timeout_cnt, pkt_timeout);
    end
    clr();
    req_valid = 4'b1001;
    cyc();
    cyc();
    wrst_n = 1'b1;
    @(negedge wclk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ar_rel_busy: got %0b want 0", busy); end
    cyc();
    @(negedge wclk);
    n_vec++; if (busy !== 1'b1 || grant_id !== 2'd0 || req_ready !== 4'b0001 || winc !== 1'b1) begin
      n_err++; $display("FAIL ar_tie: busy %0b grant %0d ready %b winc %0b want 1 0 0001 1", busy, grant_id, req_ready, winc);
    end
    cyc();
    clr();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, got stuck want done");
    $fatal(1, "bench time limit");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_watchdog();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spy_fifo_wr_arb.md
# spy_fifo_wr_arb

Write-side arbiter that shares the single write port of a SpyBuffer async FIFO between `NREQ` packet-oriented requesters in the FIFO write clock domain. Grants are round-robin and locked for a whole packet, terminated by `req_last`. The block drives `winc`/`wdata` directly and uses the FIFO's registered `wfull` flag for backpressure. A watchdog releases the lock from a requester that stalls mid-packet.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `DWIDTH`, 32: data word width.
- `MAXIDLE`, 64: consecutive idle cycles (owner's `req_valid` low) in a locked packet before the lock is released; ≥1.
- `GW`, `$clog2(NREQ)`: grant index width (derived, not overridable).

Ports:
- `wclk` in 1: write-domain clock; all logic is on the rising edge.
- `wrst_n` in 1: reset, asynchronous assert, active-low.
- `req_valid` in NREQ: per-requester word valid.
- `req_last` in NREQ: per-requester last word of packet; qualified by valid.
- `req_data` in NREQ*DWIDTH: requester i occupies bits [i*DWIDTH +: DWIDTH].
- `req_ready` out NREQ: word accepted when `req_valid[i] & req_ready[i]`.
- `wfull` in 1: FIFO full flag, registered and reflecting writes up to the previous cycle.
- `winc` out 1: FIFO write enable.
- `wdata` out DWIDTH: FIFO write data.
- `grant_id` out GW: current or last owner index.
- `busy` out 1: high while a packet lock is held.
- `pkt_timeout` out 1: one-cycle pulse on watchdog release.
- `timeout_cnt` out 16: saturating count of watchdog releases.

## Operation
- FSM with two states: IDLE and LOCK.
- **IDLE**
  - If any `req_valid` is high, select the first valid index searching upward, with wrap, from `(last_owner+1) mod NREQ`.
  - Register that index as `owner`, set `grant_id = owner`, and go to LOCK.
  - No beats are transferred in IDLE.
- **LOCK**
  - `req_ready[owner] = ~wfull`; all other `req_ready` bits are 0.
  - `winc = req_valid[owner] & ~wfull`.
  - `wdata = req_data[owner]`, combinational mux.
  - A beat with `req_last[owner]` accepted: set `last_owner = owner`, return to IDLE.
  - A single-word packet (valid and last together) is legal.
- **Watchdog** (LOCK only)
  - The idle counter increments when `req_valid[owner]` = 0.
  - It holds when valid is high but `wfull` is high, because FIFO backpressure is not the requester's fault.
  - It clears on any accepted beat and on entry to LOCK.
  - When the counter reaches `MAXIDLE`:
    - Pulse `pkt_timeout` for one cycle.
    - Increment `timeout_cnt`, saturating at 0xFFFF.
    - Set `last_owner = owner` and go to IDLE.
  - The truncated packet is not marked; downstream detects it by framing.
- `wfull` is never overridden. `winc` is never high while `wfull` is high.
- `req_last` without `req_valid` is ignored.
- A requester's `req_valid`/`req_last` changing while it is not owner has no effect.
- Reset values:
  - Outputs: `winc`=0, `req_ready`=0, `busy`=0, `grant_id`=0, `pkt_timeout`=0, `timeout_cnt`=0, `wdata`=0.
  - Internal: state=IDLE, `owner`=0, `last_owner`=NREQ-1 (requester 0 has first priority), idle counter=0.
- Reset asserted mid-packet drops the lock immediately. The partial packet stays in the FIFO.

## Timing
- Arbitration latency: valid seen in IDLE at cycle N → `busy`=1 and first possible beat at cycle N+1.
- One bubble per packet: the earliest next grant is the cycle after the last beat, and its first beat comes one cycle after that.
- A packet of L words with `wfull` low and valid held high occupies L+1 cycles of the port.
- `winc`, `req_ready` and `wdata` are combinational from `wfull`, `req_valid`, `req_data` and registered state. There is no added latency.
- `pkt_timeout` asserts in the cycle after the idle counter reaches `MAXIDLE`, coincident with `busy` falling.

## Test plan
- **Single requester.** Req 2 sends a 4-word packet, data 0xA0..0xA3, `wfull`=0.
  - `busy` rises 1 cycle after valid.
  - `winc` is high for 4 consecutive cycles with 0xA0..0xA3.
  - `grant_id`=2; back to IDLE after the last beat.
- **Round-robin fairness.** All 4 requesters continuously send 2-word packets.
  - Grant order is 0,1,2,3,0,…
  - Each packet is contiguous, never interleaved.
  - 3 port cycles per packet.
- **Backpressure.** Hold `wfull`=1 for 5 cycles mid-packet.
  - `winc`=0 and `req_ready`=0 throughout.
  - The idle counter does not advance.
  - The packet resumes intact when `wfull` falls.
- **Watchdog.** With `MAXIDLE`=8, the owner drops valid after word 1 of 3.
  - `pkt_timeout` pulses after 8 idle cycles.
  - `timeout_cnt` goes 0→1.
  - The next valid requester is granted.
  - Force 0xFFFF prior timeouts (or use a shortened bench count): `timeout_cnt` stays at 0xFFFF.
- **Async reset mid-packet.** Assert `wrst_n` low during word 2.
  - All outputs go to their reset values without waiting for a clock edge.
  - After release, requester 0 wins a tie against requester 3.
